uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (tx_data / new_tx_data / tx_busy) between NUM_REQ byte sources, e.g. the bit-reversal message printer, a keyboard echo path and a status reporter.
- Selects requesters round-robin and issues exactly one transmitter launch per granted byte.
- A per-requester lock keeps the grant across a multi-byte message so that messages from different sources never interleave.

---
 rtl/uart_tx_arbiter_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmitter arbiter and its round-robin picker.
package uart_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HOLD   = 3'd4
  } arb_state_e;

  // Index width for n requesters, never below 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter signal bundle; master = requesters + transmitter, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  import uart_arb_pkg::*;

  localparam int unsigned IDW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        ack;
  logic [BYTE_W-1:0]         tx_data;
  logic                      new_tx_data;
  logic                      tx_busy;
  logic [IDW-1:0]            owner;
  logic                      owner_valid;

  modport master (
    output req, req_data, req_lock, tx_busy,
    input  ack, tx_data, new_tx_data, owner, owner_valid
  );

  modport slave (
    input  req, req_data, req_lock, tx_busy,
    output ack, tx_data, new_tx_data, owner, owner_valid
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after rr_ptr, wrapping modulo NUM_REQ.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDW     = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  output logic [IDW-1:0]     winner_o,
  output logic               any_req_o
);

  logic [IDW-1:0] sel;

  // Walk the offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    winner_o  = '0;
    any_req_o = |req_i;
    sel       = '0;
    for (int unsigned off = NUM_REQ; off > 0; off--) begin
      sel = IDW'((32'(rr_ptr_i) + off) % NUM_REQ);
      if (req_i[sel]) winner_o = sel;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources, with per-source message lock.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDW     = idx_width(NUM_REQ)
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.slave  bus
);

  arb_state_e          state_q, state_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                new_tx_q, new_tx_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [IDW-1:0]      owner_q, owner_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                owner_valid_q, owner_valid_d;

  logic [IDW-1:0]      winner;
  logic                any_req;
  logic [BYTE_W-1:0]   req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = bus.req_data[BYTE_W*g +: BYTE_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i     (bus.req),
    .rr_ptr_i  (rr_ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.tx_busy && any_req) begin
          tx_data_d = req_bytes[winner];
          owner_d   = winner;
          rr_ptr_d  = winner;
          state_d   = ST_SEND;
        end
      end
      ST_SEND:   state_d = ST_SETTLE;
      // Transmitter busy may still be low here; it is registered on its side.
      ST_SETTLE: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.tx_busy) begin
          if (bus.req_lock[owner_q] && bus.req[owner_q]) begin
            tx_data_d = req_bytes[owner_q];
            state_d   = ST_SEND;
          end else if (bus.req_lock[owner_q]) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (bus.req[owner_q] && !bus.tx_busy) begin
          tx_data_d = req_bytes[owner_q];
          state_d   = ST_SEND;
        end else if (!bus.req_lock[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobe, ack and owner_valid are flopped from the next state so they line up with SEND.
    new_tx_d      = (state_d == ST_SEND);
    ack_d         = '0;
    if (state_d == ST_SEND) ack_d[owner_d] = 1'b1;
    owner_valid_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tx_data_q     <= '0;
      new_tx_q      <= 1'b0;
      ack_q         <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= IDW'(NUM_REQ - 1);
      owner_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      new_tx_q      <= new_tx_d;
      ack_q         <= ack_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_valid_q <= owner_valid_d;
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_tx_q;
  assign bus.ack         = ack_q;
  assign bus.owner       = owner_q;
  assign bus.owner_valid = owner_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of queued-message scenarios, hand-written timing cases, randomized rounds.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int unsigned NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [NR][64];
  int         head [NR];
  int         tail [NR];
  bit         lock_en [NR];
  bit         hold_lock [NR];
  bit         force_busy;
  int         busy_cnt;
  int         busy_len;
  logic       prev_ntx;
  logic [7:0] log_data [$];
  int         log_own [$];
  int         mdl_last;

  typedef struct {
    int          n0;
    int          n1;
    logic [23:0] d0;
    logic [23:0] d1;
    logic [1:0]  lk;
    int          ne;
    logic [47:0] ex;
    logic [5:0]  eo;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    if (head[i] == tail[i]) begin
      head[i] = 0;
      tail[i] = 0;
    end
    mem[i][tail[i]] = b;
    tail[i]++;
  endtask

  task automatic drive();
    bit ne;
    for (int i = 0; i < NR; i++) begin
      ne = (head[i] != tail[i]);
      bus.req[i]            = ne;
      bus.req_data[8*i +: 8] = ne ? mem[i][head[i]] : 8'h00;
      bus.req_lock[i]       = (lock_en[i] && ne) || hold_lock[i];
    end
    bus.tx_busy = force_busy || (busy_cnt > 0);
  endtask

  // One clock: observe at the falling edge, then update requesters and the transmitter model.
  task automatic cycle();
    logic smp_busy;
    @(negedge clk);
    smp_busy = bus.tx_busy;
    if (bus.new_tx_data === 1'b1) begin
      check("strobe_len", 32'(prev_ntx), 0);
      check("launch_while_busy", 32'(smp_busy), 0);
      check("ack_onehot", 32'(bus.ack), 32'd1 << bus.owner);
      log_data.push_back(bus.tx_data);
      log_own.push_back(int'(bus.owner));
    end else if (bus.ack !== '0) begin
      check("ack_without_strobe", 32'(bus.ack), 0);
    end
    prev_ntx = bus.new_tx_data;
    for (int i = 0; i < NR; i++)
      if (bus.ack[i] === 1'b1 && head[i] != tail[i]) head[i]++;
    if (bus.new_tx_data === 1'b1) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++)
      if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (k < budget && !(all_empty() && bus.owner_valid === 1'b0 && busy_cnt == 0 && !force_busy)) begin
      cycle();
      k++;
    end
    check({name, "_settle"}, 32'(k < budget), 1);
  endtask

  task automatic compare(input int start, input logic [7:0] ed [$], input int eo [$], input string tag);
    check({tag, "_count"}, 32'(log_data.size() - start), 32'(ed.size()));
    for (int k = 0; k < ed.size(); k++) begin
      if (start + k < log_data.size()) begin
        check($sformatf("%s_byte%0d", tag, k), 32'(log_data[start+k]), 32'(ed[k]));
        check($sformatf("%s_owner%0d", tag, k), 32'(log_own[start+k]), 32'(eo[k]));
      end
    end
  endtask

  // Reference order: round-robin over non-empty sources; a locked source sends its whole queue.
  task automatic model(input int n [NR], input logic [7:0] dat [NR][4], input bit lk [NR],
                       output logic [7:0] ed [$], output int eo [$]);
    int rem [NR];
    int pos [NR];
    int p, w, c, left;
    ed = {};
    eo = {};
    left = 0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = n[i];
      pos[i] = 0;
      left  += n[i];
    end
    p = mdl_last;
    while (left > 0) begin
      w = -1;
      for (int off = 1; off <= NR; off++) begin
        c = (p + off) % NR;
        if (w < 0 && rem[c] > 0) w = c;
      end
      do begin
        ed.push_back(dat[w][pos[w]]);
        eo.push_back(w);
        pos[w]++;
        rem[w]--;
        left--;
      end while (lk[w] && rem[w] > 0);
      p = w;
    end
    mdl_last = p;
  endtask

  initial begin
    logic [7:0] ed [$];
    int         eo [$];
    int         ls, ls2, n [NR];
    logic [7:0] dat [NR][4];
    bit         lk [NR];
    bit         ov_ok;

    vecs[0] = '{2, 2, 24'h003030, 24'h003131, 2'b00, 4, 48'h0000_3130_3130, 6'b001010};
    vecs[1] = '{1, 0, 24'h000041, 24'h000000, 2'b00, 1, 48'h0000_0000_0041, 6'b000000};
    vecs[2] = '{1, 3, 24'h000058, 24'h564552, 2'b10, 4, 48'h0000_5856_4552, 6'b000111};
    vecs[3] = '{2, 1, 24'h00A1A0, 24'h0000B0, 2'b01, 3, 48'h0000_00A1_A0B0, 6'b000001};
    vecs[4] = '{2, 2, 24'h00C1C0, 24'h00D1D0, 2'b11, 4, 48'h0000_C1C0_D1D0, 6'b000011};
    vecs[5] = '{0, 1, 24'h000000, 24'h0000E1, 2'b00, 1, 48'h0000_0000_00E1, 6'b000001};
    vecs[6] = '{3, 0, 24'hF2F1F0, 24'h000000, 2'b00, 3, 48'h0000_00F2_F1F0, 6'b000000};

    for (int i = 0; i < NR; i++) begin
      head[i] = 0; tail[i] = 0; lock_en[i] = 0; hold_lock[i] = 0;
    end
    force_busy = 0;
    busy_cnt   = 0;
    busy_len   = 10;
    prev_ntx   = 0;
    mdl_last   = NR - 1;
    drive();

    run(3);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_new_tx_data", 32'(bus.new_tx_data), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_owner", 32'(bus.owner), 0);
    check("rst_owner_valid", 32'(bus.owner_valid), 0);
    rst = 1'b0;
    run(2);

    for (int r = 0; r < 7; r++) begin
      lock_en[0] = vecs[r].lk[0];
      lock_en[1] = vecs[r].lk[1];
      busy_len   = 10;
      for (int k = 0; k < vecs[r].n0; k++) push(0, vecs[r].d0[8*k +: 8]);
      for (int k = 0; k < vecs[r].n1; k++) push(1, vecs[r].d1[8*k +: 8]);
      ed = {};
      eo = {};
      for (int k = 0; k < vecs[r].ne; k++) begin
        ed.push_back(vecs[r].ex[8*k +: 8]);
        eo.push_back(int'(vecs[r].eo[k]));
      end
      ls = log_data.size();
      drive();
      wait_idle(600, $sformatf("vec%0d", r));
      compare(ls, ed, eo, $sformatf("vec%0d", r));
      lock_en[0] = 0;
      lock_en[1] = 0;
      mdl_last = eo[eo.size()-1];
    end

    // Launch latency from an idle arbiter with the transmitter free.
    push(0, 8'h11);
    drive();
    cycle();
    check("lat_new_tx_data", 32'(bus.new_tx_data), 1);
    check("lat_ack", 32'(bus.ack), 32'b01);
    check("lat_tx_data", 32'(bus.tx_data), 32'h11);
    wait_idle(100, "lat");

    // Locked owner with nothing to send keeps others out until it releases.
    hold_lock[1] = 1;
    push(1, 8'h61);
    drive();
    ls = log_data.size();
    run(20);
    check("hold_first_count", 32'(log_data.size() - ls), 1);
    check("hold_first_byte", 32'(log_data[ls]), 32'h61);
    check("hold_owner_valid_entry", 32'(bus.owner_valid), 1);
    check("hold_owner_entry", 32'(bus.owner), 1);
    push(0, 8'h62);
    drive();
    ls2 = log_data.size();
    ov_ok = 1;
    repeat (20) begin
      cycle();
      if (bus.owner_valid !== 1'b1) ov_ok = 0;
    end
    check("hold_blocks_others", 32'(log_data.size() - ls2), 0);
    check("hold_owner_valid", 32'(ov_ok), 1);
    push(1, 8'h63);
    drive();
    ls2 = log_data.size();
    run(25);
    check("hold_relaunch_count", 32'(log_data.size() - ls2), 1);
    check("hold_relaunch_byte", 32'(log_data[ls2]), 32'h63);
    check("hold_relaunch_owner", 32'(log_own[ls2]), 1);
    hold_lock[1] = 0;
    drive();
    cycle();
    check("release_owner_valid", 32'(bus.owner_valid), 0);
    cycle();
    check("release_new_tx_data", 32'(bus.new_tx_data), 1);
    check("release_tx_data", 32'(bus.tx_data), 32'h62);
    check("release_owner", 32'(bus.owner), 0);
    wait_idle(100, "release");

    // Busy transmitter holds off a pending request.
    force_busy = 1;
    drive();
    cycle();
    push(0, 8'h77);
    drive();
    ls = log_data.size();
    run(50);
    check("busy_gate_no_launch", 32'(log_data.size() - ls), 0);
    force_busy = 0;
    busy_cnt   = 0;
    drive();
    cycle();
    check("busy_gate_launch", 32'(bus.new_tx_data), 1);
    check("busy_gate_data", 32'(bus.tx_data), 32'h77);
    wait_idle(100, "busy_gate");

    // Asynchronous reset while draining a byte.
    push(1, 8'h91);
    drive();
    cycle();
    check("drain_launch_data", 32'(bus.tx_data), 32'h91);
    run(2);
    force_busy = 1;
    push(0, 8'h90);
    push(1, 8'h92);
    drive();
    #2 rst = 1'b1;
    #1;
    check("arst_ack", 32'(bus.ack), 0);
    check("arst_new_tx_data", 32'(bus.new_tx_data), 0);
    check("arst_tx_data", 32'(bus.tx_data), 0);
    check("arst_owner", 32'(bus.owner), 0);
    check("arst_owner_valid", 32'(bus.owner_valid), 0);
    cycle();
    rst = 1'b0;
    busy_cnt = 0;
    ls = log_data.size();
    run(5);
    check("arst_wait_busy", 32'(log_data.size() - ls), 0);
    force_busy = 0;
    drive();
    cycle();
    check("arst_first_launch", 32'(bus.new_tx_data), 1);
    check("arst_first_data", 32'(bus.tx_data), 32'h90);
    check("arst_first_owner", 32'(bus.owner), 0);
    wait_idle(100, "arst");
    check("arst_second_data", 32'(log_data[log_data.size()-1]), 32'h92);
    check("arst_second_owner", 32'(log_own[log_own.size()-1]), 1);
    mdl_last = 1;

    for (int r = 0; r < 15; r++) begin
      do begin
        for (int i = 0; i < NR; i++) n[i] = $urandom_range(0, 3);
      end while (n[0] + n[1] == 0);
      for (int i = 0; i < NR; i++) begin
        lk[i] = bit'($urandom_range(0, 1));
        for (int k = 0; k < 4; k++) dat[i][k] = 8'($urandom);
      end
      busy_len = $urandom_range(1, 12);
      model(n, dat, lk, ed, eo);
      for (int i = 0; i < NR; i++) begin
        lock_en[i] = lk[i];
        for (int k = 0; k < n[i]; k++) push(i, dat[i][k]);
      end
      ls = log_data.size();
      drive();
      wait_idle(600, $sformatf("rnd%0d", r));
      compare(ls, ed, eo, $sformatf("rnd%0d", r));
      for (int i = 0; i < NR; i++) lock_en[i] = 0;
      drive();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
